// File: rtl/axis_pkt_deser_if.sv
// Byte-oriented valid/ready stream with packet framing (sop/eop), a byte-count
// modifier on the last beat, a sideband control field and an error flag.
interface if_axi_stream #(
    parameter int DAT_BYTS = 8,
    parameter int CTL_BITS = 8,
    parameter int MOD_BITS = (DAT_BYTS > 1) ? $clog2(DAT_BYTS) : 1
);
    logic [DAT_BYTS*8-1:0] dat;
    logic                  val;
    logic                  rdy;
    logic                  sop;
    logic                  eop;
    logic [MOD_BITS-1:0]   mod;
    logic [CTL_BITS-1:0]   ctl;
    logic                  err;

    modport source (output dat, val, sop, eop, mod, ctl, err, input rdy);
    modport sink   (input dat, val, sop, eop, mod, ctl, err, output rdy);
endinterface

// File: rtl/axis_pkt_deser.sv
// Stream-to-wide-word deserialiser: gathers one sop..eop packet into a single
// MAX_BEATS*DAT_BITS word with length/ctl/err. Define AXIS_PKT_DESER_STATS_EN for drop/packet counters.
module axis_pkt_deser #(
    parameter int DAT_BYTS  = 8,
    parameter int DAT_BITS  = DAT_BYTS * 8,
    parameter int CTL_BITS  = 8,
    parameter int MAX_BEATS = 6,
    parameter int LEN_BITS  = $clog2(MAX_BEATS * DAT_BYTS + 1)
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    if_axi_stream.sink                    i_if,
    output logic [MAX_BEATS*DAT_BITS-1:0] o_dat,
    output logic [LEN_BITS-1:0]           o_len,
    output logic [CTL_BITS-1:0]           o_ctl,
    output logic                          o_err,
    output logic                          o_val,
    input  logic                          o_rdy
`ifdef AXIS_PKT_DESER_STATS_EN
    ,
    output logic [15:0]                   o_drop_cnt,
    output logic [15:0]                   o_pkt_cnt
`endif
);

    localparam int OUT_BITS = MAX_BEATS * DAT_BITS;
    localparam int CNT_BITS = $clog2(MAX_BEATS + 1);
    localparam logic [LEN_BITS-1:0] MAX_LEN = LEN_BITS'(MAX_BEATS * DAT_BYTS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DROP    = 2'd2,
        HOLD    = 2'd3
    } state_t;

    state_t              state;
    logic [CNT_BITS-1:0] cnt;
    logic                err_acc;
    logic                beat_acc;
    logic [LEN_BITS-1:0] tail_len;
    logic [LEN_BITS-1:0] body_len;

    // Ready is held low during reset so no beat is taken before the FSM is live.
    assign i_if.rdy = i_rst_n && (state != HOLD);
    assign beat_acc = i_if.val && i_if.rdy;

    // tail_len is the byte count of the current beat if it is the last one;
    // body_len is the bytes contributed by the beats already stored.
    always_comb begin
        tail_len = (i_if.mod == '0) ? LEN_BITS'(DAT_BYTS) : LEN_BITS'(i_if.mod);
        body_len = LEN_BITS'(int'(cnt) * DAT_BYTS);
    end

`ifdef AXIS_PKT_DESER_STATS_EN
    logic drop_evt;

    // One drop event per orphan beat, per abandoned partial packet and per overflow.
    always_comb begin
        drop_evt = 1'b0;
        if (beat_acc) begin
            case (state)
                IDLE:    drop_evt = !i_if.sop;
                COLLECT: drop_evt = i_if.sop || (cnt == CNT_BITS'(MAX_BEATS));
                default: drop_evt = 1'b0;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_drop_cnt <= '0;
            o_pkt_cnt  <= '0;
        end else begin
            if (drop_evt && (o_drop_cnt != 16'hFFFF))
                o_drop_cnt <= o_drop_cnt + 16'd1;
            if (o_val && o_rdy)
                o_pkt_cnt <= o_pkt_cnt + 16'd1;
        end
    end
`endif

    // Packet FSM. Beats are written straight into o_dat; it is only presented
    // (o_val) once the packet is closed, and is frozen for the whole of HOLD.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            err_acc <= 1'b0;
            o_dat   <= '0;
            o_len   <= '0;
            o_ctl   <= '0;
            o_err   <= 1'b0;
            o_val   <= 1'b0;
        end else begin
            case (state)
                HOLD: begin
                    if (o_val && o_rdy) begin
                        state <= IDLE;
                        o_val <= 1'b0;
                    end
                end
                DROP: begin
                    if (beat_acc && i_if.eop) begin
                        state <= HOLD;
                        o_val <= 1'b1;
                        o_err <= 1'b1;
                        o_len <= MAX_LEN;
                    end
                end
                default: begin
                    if (beat_acc) begin
                        if (i_if.sop) begin
                            // New packet, from IDLE or abandoning a partial one.
                            o_dat   <= OUT_BITS'(i_if.dat);
                            o_ctl   <= i_if.ctl;
                            err_acc <= i_if.err;
                            cnt     <= CNT_BITS'(1);
                            if (i_if.eop) begin
                                state <= HOLD;
                                o_val <= 1'b1;
                                o_err <= i_if.err;
                                o_len <= tail_len;
                            end else begin
                                state <= COLLECT;
                            end
                        end else if (state == COLLECT) begin
                            if (cnt == CNT_BITS'(MAX_BEATS)) begin
                                // No room left: the packet is reported truncated.
                                if (i_if.eop) begin
                                    state <= HOLD;
                                    o_val <= 1'b1;
                                    o_err <= 1'b1;
                                    o_len <= MAX_LEN;
                                end else begin
                                    state <= DROP;
                                end
                            end else begin
                                o_dat[int'(cnt)*DAT_BITS +: DAT_BITS] <= i_if.dat;
                                cnt     <= cnt + CNT_BITS'(1);
                                err_acc <= err_acc | i_if.err;
                                if (i_if.eop) begin
                                    state <= HOLD;
                                    o_val <= 1'b1;
                                    o_err <= err_acc | i_if.err;
                                    o_len <= body_len + tail_len;
                                end
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/axis_pkt_deser.md
Name: axis_pkt_deser

Overview:
- Stream sink: consumes if_axi_stream packets (sop..eop) and assembles them into one wide word plus metadata.
- Output is a simple val/rdy handshake.
- Sits at the receive end of stream pipelines, e.g. collecting multi-beat field elements back into a full-width operand for the arithmetic cores.
- Holds one packet at a time; backpressures the stream while the assembled word is waiting.

Parameters:
DAT_BYTS, 8, bytes per stream beat
DAT_BITS, DAT_BYTS*8, stream data width
CTL_BITS, 8, sideband ctl width
MAX_BEATS, 6, max beats per packet (output width = MAX_BEATS*DAT_BITS)
LEN_BITS, $clog2(MAX_BEATS*DAT_BYTS+1), byte-length field width

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset, asynchronous, active-low
i_if  if_axi_stream.sink  DAT_BITS/CTL_BITS  input stream (dat, val, rdy, sop, eop, mod, ctl, err)
o_dat  out  MAX_BEATS*DAT_BITS  assembled packet; beat k at bits [k*DAT_BITS +: DAT_BITS]
o_len  out  LEN_BITS  packet length in bytes
o_ctl  out  CTL_BITS  ctl captured on sop beat
o_err  out  1  packet error (input err seen, or overflow)
o_val  out  1  assembled word valid
o_rdy  in  1  downstream accepts word

Behaviour:
- Reset (async assert, sync release): state=IDLE, o_val=0, o_dat=0, o_len=0, o_ctl=0, o_err=0, beat cnt=0. i_if.rdy=0 while i_rst_n=0.
- i_if.rdy = (state != HOLD). Combinational from the state register only; never depends on i_if.val.
- Beat accepted when i_if.val && i_if.rdy.
- States:
  - IDLE: accepted beat with sop → clear o_dat, write beat 0, capture ctl, err acc = i_if.err, cnt=1. Go to HOLD if eop, else COLLECT. Accepted beat without sop (orphan) → discarded, stay IDLE.
  - COLLECT: accepted beat written at index cnt, cnt++, err acc |= i_if.err. Beat with sop restarts the packet exactly as in IDLE; the partial packet is dropped with no output. On eop → HOLD. Non-eop beat when cnt==MAX_BEATS → DROP.
  - DROP: accept and discard beats; on eop → HOLD with o_err=1, o_len=MAX_BEATS*DAT_BYTS. A sop seen in DROP is treated as data, not a restart.
  - HOLD: o_val=1; o_dat/o_len/o_ctl/o_err stable. On o_val && o_rdy → IDLE next cycle, o_val=0.
- Length: o_len = (beats-1)*DAT_BYTS + (mod==0 ? DAT_BYTS : mod), using mod from the eop beat. Overflow case is forced as above.
- Unfilled upper beats of o_dat read as 0.
- Latency: o_val rises the cycle after the eop beat is accepted.
- Throughput: one bubble cycle per packet (HOLD→IDLE).
- mod on non-eop beats is ignored.

Optional Feature:
- Macro: AXIS_PKT_DESER_STATS_EN.
- Defined: adds outputs o_drop_cnt[15:0] and o_pkt_cnt[15:0], both reset to 0.
  - o_drop_cnt increments by 1 per orphan beat, per restart-dropped packet, and per overflow packet. Saturates at 0xFFFF.
  - o_pkt_cnt increments on each o_val && o_rdy. Wraps.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
1. Reset: assert i_rst_n=0 mid-COLLECT → o_val=0, i_if.rdy=0 immediately. After release: i_if.rdy=1, state IDLE.
2. Single beat: dat=0x1122334455667788, sop=eop=1, mod=0, ctl=0x5A, o_rdy=1 → next cycle o_val=1, o_dat[63:0]=0x1122334455667788, o_dat upper bits=0, o_len=8, o_ctl=0x5A, o_err=0.
3. Backpressure: 3-beat packet, eop mod=3, o_rdy=0 for 10 cycles → o_len=19, o_val held for 10 cycles with outputs stable, i_if.rdy=0 throughout. Returns to IDLE one cycle after o_rdy=1.
4. Overflow: 8-beat packet → beats 7-8 discarded, o_err=1, o_len=48, o_dat holds beats 1-6. With stats: o_drop_cnt=1.
5. Restart: beats A(sop), B, C(sop), D(eop, mod=0) → single output o_dat = {D,C}, o_len=16. With stats: o_drop_cnt=1.
6. Orphan/err: non-sop beat in IDLE → no o_val. Then 2-beat packet with err=1 on beat 1 only → o_err=1, o_len=16.
